// File: rtl/npu_pkg.sv
// Shared NPU definitions: default activation-write geometry, bank-select
// encodings and a helper that sizes index fields.
package npu_pkg;

  localparam int NPU_NUM_CH = 32;
  localparam int NPU_ADDR_W = 12;
  localparam int NPU_DATA_W = 8;

  // Bank-select encodings for the ping-pong activation buffer.
  localparam logic BANK_PING = 1'b0;
  localparam logic BANK_PONG = 1'b1;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/npu_rr_arbiter.sv
// Combinational round-robin selector.
// Grants the lowest-index requester at or above ptr, wrapping N-1 -> 0.
// Ports:
//   req        in   N   request vector
//   ptr        in   IW  search start position
//   grant      out  N   one-hot grant (all zero when nothing requested)
//   grant_idx  out  IW  index of the granted requester
//   valid      out  1   a grant was made
//   next_ptr   out  IW  (grant_idx+1) mod N after a grant, else ptr
module npu_rr_arbiter
  import npu_pkg::*;
#(
  parameter  int N  = NPU_NUM_CH,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          valid,
  output logic [IW-1:0] next_ptr
);

  always_comb begin : sel
    int pos;
    grant_idx = '0;
    valid     = 1'b0;
    pos       = 0;
    // Walk the ring starting at ptr; the first hit wins.
    for (int i = 0; i < N; i++) begin
      pos = (int'(ptr) + i) % N;
      if (!valid && req[pos]) begin
        valid     = 1'b1;
        grant_idx = IW'(pos);
      end
    end
  end

  assign grant = valid ? (N'(1) << grant_idx) : '0;

  always_comb begin
    next_ptr = ptr;
    if (valid) begin
      next_ptr = (int'(grant_idx) == N - 1) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/npu_act_wr_arbiter.sv
// Activation write arbiter: funnels per-MAC-channel write requests into a
// single activation memory write port with round-robin fairness, and manages
// ping-pong bank selection across layer boundaries.
// Ports:
//   clk, resetn         clock, async active-low reset
//   hw_mem_wr           per-channel request level, held until acked
//   hw_mem_wr_addr/data packed per-channel address / data
//   hw_mem_wr_ack_p     one-cycle ack to the channel just written
//   layer_done_p        bank swap request at end of layer
//   mem_wr_en/addr/data registered memory write port (addr MSB = bank)
//   wr_bank, rd_bank    bank being written / bank holding previous layer
//   wr_count            writes since last swap, saturating
//   busy                a request is eligible or a write is in flight
//   swap_err            sticky: swap requested while one was pending
module npu_act_wr_arbiter
  import npu_pkg::*;
#(
  parameter  int NUM_CH = NPU_NUM_CH,
  parameter  int ADDR_W = NPU_ADDR_W,
  parameter  int DATA_W = NPU_DATA_W,
  parameter  int BANKED = 1,
  localparam int MA_W   = ADDR_W + BANKED,
  localparam int IW     = idx_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        hw_mem_wr,
  input  logic [NUM_CH*ADDR_W-1:0] hw_mem_wr_addr,
  input  logic [NUM_CH*DATA_W-1:0] hw_mem_wr_data,
  output logic [NUM_CH-1:0]        hw_mem_wr_ack_p,
  input  logic                     layer_done_p,
  output logic                     mem_wr_en,
  output logic [MA_W-1:0]          mem_wr_addr,
  output logic [DATA_W-1:0]        mem_wr_data,
  output logic                     wr_bank,
  output logic                     rd_bank,
  output logic [ADDR_W:0]          wr_count,
  output logic                     busy,
  output logic                     swap_err
);

  localparam bit BANK_EN = (BANKED != 0);

  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] grant;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     grant_idx;
  logic [IW-1:0]     next_ptr;
  logic              grant_vld;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [MA_W-1:0]   addr_next;
  logic              swap_req;
  logic              swap_now;
  logic              swap_pending;

  // The channel acked this cycle still shows its old request level; mask it
  // so the same write is not issued twice.
  assign eligible = hw_mem_wr & ~hw_mem_wr_ack_p;

  npu_rr_arbiter #(.N(NUM_CH)) u_rr (
    .req       (eligible),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .valid     (grant_vld),
    .next_ptr  (next_ptr)
  );

  assign sel_addr = hw_mem_wr_addr[grant_idx*ADDR_W +: ADDR_W];
  assign sel_data = hw_mem_wr_data[grant_idx*DATA_W +: DATA_W];

  if (BANK_EN) begin : g_banked
    // Uses the pre-swap bank when a grant and a swap share an edge.
    assign addr_next = {wr_bank, sel_addr};
  end else begin : g_flat
    assign addr_next = sel_addr;
  end

  assign busy     = (|eligible) | mem_wr_en;
  assign swap_req = BANK_EN & layer_done_p;
  assign swap_now = (swap_req | swap_pending) & ~busy;
  assign rd_bank  = BANK_EN ? ~wr_bank : BANK_PING;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_wr_en       <= 1'b0;
      mem_wr_addr     <= '0;
      mem_wr_data     <= '0;
      hw_mem_wr_ack_p <= '0;
      rr_ptr          <= '0;
    end else begin
      mem_wr_en       <= grant_vld;
      hw_mem_wr_ack_p <= grant;
      rr_ptr          <= next_ptr;
      if (grant_vld) begin
        mem_wr_addr <= addr_next;
        mem_wr_data <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_bank      <= BANK_PING;
      swap_pending <= 1'b0;
      swap_err     <= 1'b0;
      wr_count     <= '0;
    end else begin
      // A swap only fires while idle, so it never coincides with a write.
      if (swap_now) begin
        wr_bank      <= ~wr_bank;
        swap_pending <= 1'b0;
        wr_count     <= '0;
      end else begin
        if (swap_req) swap_pending <= 1'b1;
        if (mem_wr_en && (wr_count != '1)) wr_count <= wr_count + (ADDR_W+1)'(1);
      end
      if (swap_req && swap_pending) swap_err <= 1'b1;
    end
  end

endmodule
